// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types, constants and redirect-target helper for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int REQ_DEPTH_W = 3;

  localparam logic [31:0] EXC_NONE       = 32'h0000_0000;
  localparam logic [31:0] EXC_MRET       = 32'h0000_000a;
  localparam logic [1:0]  MTVEC_VECTORED = 2'b01;

  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // MRET returns to mepc; vectored interrupts offset the aligned base by cause*4.
  function automatic logic [XLEN-1:0] trap_target(
    input logic [31:0]     excepttype,
    input logic [XLEN-1:0] mepc,
    input logic [XLEN-1:0] mtvec,
    input logic            vectored_en
  );
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (excepttype == EXC_MRET) begin
      return mepc;
    end
    if (excepttype[31] && vectored_en && (mtvec[1:0] == MTVEC_VECTORED)) begin
      return base + {{(XLEN-7){1'b0}}, excepttype[4:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stall_mask_gen.sv
// Merges per-source stall requests into a per-stage freeze vector; each source
// freezes stages 0..depth-1 of the pipeline.
module stall_mask_gen
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                               NUM_STAGES = 6,
  parameter int                               NUM_REQ    = 2,
  parameter logic [REQ_DEPTH_W*NUM_REQ-1:0]   REQ_DEPTH  = {3'd4, 3'd3}
) (
  input  logic [NUM_REQ-1:0]    stallreq_i,
  output logic [NUM_STAGES-1:0] stall_mask_o
);

  // Depths beyond the pipeline clamp to all ones; depth 0 yields an empty mask.
  function automatic logic [NUM_STAGES-1:0] depth_mask(input int depth);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i < depth);
    end
    return m;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    stall_mask_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (stallreq_i[k]) begin
        stall_mask_o = stall_mask_o
                     | depth_mask(int'(REQ_DEPTH[REQ_DEPTH_W*k +: REQ_DEPTH_W]));
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: trap/MRET redirect FSM with programmable flush
// length, per-stage stall merging, stall watchdog and stalled-cycle statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                             NUM_STAGES    = 6,
  parameter int                             NUM_REQ       = 2,
  parameter logic [REQ_DEPTH_W*NUM_REQ-1:0] REQ_DEPTH     = {3'd4, 3'd3},
  parameter int                             FLUSH_CYCLES  = 1,
  parameter bit                             VECTORED_EN   = 1'b1,
  parameter int                             STALL_TIMEOUT = 1023,
  parameter int                             CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [XLEN-1:0]       csr_mepc_i,
  input  logic [XLEN-1:0]       csr_mtvec_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [XLEN-1:0]       new_pc_o,
  output logic                  new_pc_valid_o,
  output logic                  stall_timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  localparam int              RUN_W      = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(STALL_TIMEOUT);
  localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [NUM_STAGES-1:0] stall_mask;
  ctrl_state_e           state_q, state_d;
  logic [3:0]            flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [CNT_W-1:0]      cycles_q, cycles_d;
  logic                  exc_take;
  logic                  flush_raw;
  logic                  stalled;

  stall_mask_gen #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_REQ    (NUM_REQ),
    .REQ_DEPTH  (REQ_DEPTH)
  ) u_stall_mask_gen (
    .stallreq_i   (stallreq_i),
    .stall_mask_o (stall_mask)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    exc_take    = 1'b0;
    flush_raw   = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (excepttype_i != EXC_NONE) begin
          exc_take    = 1'b1;
          flush_raw   = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) state_d = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        flush_raw   = 1'b1;
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q <= 4'd1) state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so flush drops without a clock edge.
  assign flush_o         = flush_raw && !rst;
  assign new_pc_valid_o  = exc_take && !rst;
  assign stall_o         = (flush_raw || rst) ? '0 : stall_mask;
  assign new_pc_o        = new_pc_valid_o
                         ? trap_target(excepttype_i, csr_mepc_i, csr_mtvec_i, VECTORED_EN)
                         : '0;
  assign stalled         = |stall_o;
  assign stall_timeout_o = (run_q == RUN_MAX);
  assign stall_cycles_o  = cycles_q;

  always_comb begin
    run_d    = run_q;
    cycles_d = cycles_q;
    if (!stalled) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
    if (stalled && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset acts without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CTRL_IDLE;
      flush_cnt_q <= '0;
      run_q       <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      run_q       <= run_d;
      cycles_q    <= cycles_d;
    end
  end

endmodule
